conv_1x1_weight_scheduler: RTL and testbench
============================================

# conv_1x1_weight_scheduler

Sequencer for the 1x1-convolution weight buffer (DFF stage + delay FIFO, depth WEIGHT_NUM). It accepts one kernel's weights from the weight stream, writes them into the buffer, then issues one read pulse per weight for every output pixel. It also reports pixel/weight progress to the MAC datapath. It sits between the weight loader and the buffer and owns the buffer's write, read and data inputs.

## Interface
- DATA_WIDTH, 32, weight word width
- WEIGHT_NUM, 4, weights per kernel (buffer depth)
- PIXEL_NUM, 16, output pixels per kernel pass
- CNT_WIDTH, 5, counter width; must satisfy 2^CNT_WIDTH > max(WEIGHT_NUM, PIXEL_NUM)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a kernel; sampled only in IDLE
- w_valid  in  1  weight stream valid
- w_data  in  DATA_WIDTH  weight stream data
- w_ready  out  1  weight stream ready; high only in LOAD
- pix_ready  in  1  MAC can accept the next weight this cycle
- buf_rdata  in  DATA_WIDTH  buffer read data, valid the cycle after buf_read
- buf_valid_in  out  1  buffer write strobe (into buffer DFF stage)
- buf_wdata  out  DATA_WIDTH  buffer write data
- buf_read  out  1  buffer read pulse (buffer load_weights)
- w_idx  out  CNT_WIDTH  index of weight read this cycle
- pix_idx  out  CNT_WIDTH  current pixel index
- last_w  out  1  with buf_read on weight WEIGHT_NUM-1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of kernel

## Operation
- Reset: state IDLE; all outputs 0; w_idx and pix_idx 0.
- IDLE: on start go to LOAD and clear both counters.
- LOAD: w_ready=1. Each w_valid&w_ready beat drives buf_valid_in=1 and buf_wdata=w_data in the same cycle (combinational pass-through) and increments w_idx. After beat WEIGHT_NUM-1, go to SETTLE and clear w_idx.
- SETTLE: 1 cycle. Covers the buffer's DFF write latency.
- RUN: buf_read = pix_ready. Each read increments w_idx. last_w is asserted on the read with w_idx=WEIGHT_NUM-1; that read wraps w_idx to 0 and increments pix_idx.
- On the read with w_idx=WEIGHT_NUM-1 and pix_idx=PIXEL_NUM-1, go to DRAIN.
- DRAIN: 2 cycles, so the last recirculated write lands. Then go to IDLE with done=1 on the transition cycle.
- Counter arithmetic is unsigned with wrap at WEIGHT_NUM / PIXEL_NUM. They never wrap at 2^CNT_WIDTH.
- start outside IDLE is ignored.
- w_valid outside LOAD is ignored and not consumed.
- pix_ready outside RUN is ignored.
- Reset in any state returns to IDLE within one cycle. Buffer contents are then undefined; the next start reloads them.

## Timing
- Write latency: w_data is accepted at edge N and is readable from the buffer after edge N+2. SETTLE guarantees this.
- Read: buf_read at edge N yields buf_rdata after edge N+1.
- Peak throughput: one weight per cycle while pix_ready=1. pix_ready low stalls RUN with no counter change.
- Kernel duration with pix_ready tied high: WEIGHT_NUM + 1 + WEIGHT_NUM·PIXEL_NUM + 2 cycles from first accepted beat to done.
- done and busy never both pulse in the same cycle after DRAIN: busy is low when done=1.

## Configuration
- CONV1X1_WSCHED_RECIRC_EN defined:
  - The cycle after each buf_read, the scheduler drives buf_valid_in=1 and buf_wdata=buf_rdata, writing the weight back to the buffer tail.
  - The buffer therefore holds the kernel for all PIXEL_NUM passes.
  - Recirculation writes never coincide with LOAD writes.
- Undefined:
  - No recirculation. Effectively PIXEL_NUM=1: RUN ends after WEIGHT_NUM reads.
  - DRAIN is 1 cycle.
  - The loader must restart the scheduler per pixel.

## Test plan
- Reset mid-RUN (pix_idx=5, w_idx=2) -> next cycle busy=0, all outputs 0; subsequent start loads cleanly.
- start, weights 0x11,0x22,0x33,0x44 back-to-back, pix_ready=1, RECIRC_EN -> buf_rdata sequence 11,22,33,44 repeated 16 times; last_w on every 4th read; done exactly 70 cycles after the first beat.
- Same as above, but toggle pix_ready 1/0 every cycle -> identical data order; RUN length doubles; no counter change on stall cycles.
- w_valid gaps (beats 1 and 3 delayed 3 cycles) -> w_ready high throughout LOAD; exactly 4 buffer writes; no extra writes.
- start and w_valid asserted during RUN -> ignored; w_ready=0; kernel data unchanged.
- RECIRC_EN undefined, weights A,B,C,D -> 4 reads A..D, then done; no buf_valid_in during RUN.

Source files
------------

// File: rtl/conv_1x1_weight_scheduler.sv
// conv_1x1_weight_scheduler
// Sequencer for the 1x1-convolution weight buffer. Loads one kernel from the
// weight stream into the buffer, then issues one read per weight for every
// output pixel while reporting weight/pixel progress to the MAC datapath.
//
// Build option: define CONV1X1_WSCHED_RECIRC_EN to write every read weight
// back to the buffer tail, so one load serves all PIXEL_NUM pixels. Without
// it, one pass of WEIGHT_NUM reads ends the kernel and the loader restarts
// the scheduler per pixel.
module conv_1x1_weight_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int WEIGHT_NUM = 4,
  parameter int PIXEL_NUM  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  buf_valid_in,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  output logic                  buf_read,
  output logic [CNT_WIDTH-1:0]  w_idx,
  output logic [CNT_WIDTH-1:0]  pix_idx,
  output logic                  last_w,
  output logic                  busy,
  output logic                  done
);

`ifdef CONV1X1_WSCHED_RECIRC_EN
  localparam bit RECIRC_EN = 1'b1;
`else
  localparam bit RECIRC_EN = 1'b0;
`endif

  // Without recirculation the buffer is consumed by a single pass.
  localparam int PASS_NUM = RECIRC_EN ? PIXEL_NUM : 1;
  localparam logic [CNT_WIDTH-1:0] W_LAST = CNT_WIDTH'(WEIGHT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] P_LAST = CNT_WIDTH'(PASS_NUM - 1);
  // Value of drain_q on the final DRAIN cycle: two cycles with recirculation
  // so the last write-back lands, one cycle otherwise.
  localparam logic DRAIN_LAST = RECIRC_EN ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [CNT_WIDTH-1:0] pix_idx_q, pix_idx_d;
  logic                 drain_q, drain_d;
  logic                 read_q, read_d;
  logic                 done_q, done_d;

  // State and counter registers.
  // NOTE: reset is synchronous here, and all state updates use non-blocking
  // assignments so every flop samples pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      w_idx_q   <= '0;
      pix_idx_q <= '0;
      drain_q   <= 1'b0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_idx_q   <= w_idx_d;
      pix_idx_q <= pix_idx_d;
      drain_q   <= drain_d;
      read_q    <= read_d;
      done_q    <= done_d;
    end
  end

  // Next-state, counter update and buffer control outputs.
  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    w_idx_d      = w_idx_q;
    pix_idx_d    = pix_idx_q;
    drain_d      = drain_q;
    read_d       = 1'b0;
    done_d       = 1'b0;
    w_ready      = 1'b0;
    buf_valid_in = 1'b0;
    buf_wdata    = '0;
    buf_read     = 1'b0;
    last_w       = 1'b0;

    // Write back the weight read out on the previous cycle. read_q can only
    // be set in RUN, so this never collides with a LOAD write.
    if (read_q) begin
      buf_valid_in = 1'b1;
      buf_wdata    = buf_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          w_idx_d   = '0;
          pix_idx_d = '0;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          buf_valid_in = 1'b1;
          buf_wdata    = w_data;
          if (w_idx_q == W_LAST) begin
            w_idx_d = '0;
            state_d = S_SETTLE;
          end else begin
            w_idx_d = w_idx_q + CNT_WIDTH'(1);
          end
        end
      end
      // One idle cycle covers the buffer's DFF write latency.
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        buf_read = pix_ready;
        read_d   = pix_ready & RECIRC_EN;
        if (pix_ready) begin
          if (w_idx_q == W_LAST) begin
            last_w  = 1'b1;
            w_idx_d = '0;
            if (pix_idx_q == P_LAST) begin
              pix_idx_d = '0;
              drain_d   = 1'b0;
              state_d   = S_DRAIN;
            end else begin
              pix_idx_d = pix_idx_q + CNT_WIDTH'(1);
            end
          end else begin
            w_idx_d = w_idx_q + CNT_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered so it appears in the first IDLE cycle, when busy is
  // already low.
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign w_idx   = w_idx_q;
  assign pix_idx = pix_idx_q;

endmodule

// File: tb/tb_conv_1x1_weight_scheduler.sv
// Self-checking bench for conv_1x1_weight_scheduler. A behavioural weight
// buffer (one DFF stage feeding a WEIGHT_NUM-deep FIFO) closes the loop so
// read data and recirculation are observable. Expectations come from the
// kernel rules: read r returns weight r mod WEIGHT_NUM, done timing follows
// from counting pix_ready-high cycles after the load.
`timescale 1ns/1ps
module tb_conv_1x1_weight_scheduler;
  localparam int DW = 32;
  localparam int WN = 4;
  localparam int PN = 16;
  localparam int CW = 5;
`ifdef CONV1X1_WSCHED_RECIRC_EN
  localparam int PASSES = PN;
  localparam int DRAIN  = 2;
`else
  localparam int PASSES = 1;
  localparam int DRAIN  = 1;
`endif
  localparam int TOTAL = WN * PASSES;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          pix_ready = 1'b0;
  logic [DW-1:0] buf_rdata = '0;
  logic          w_ready, buf_valid_in, buf_read, last_w, busy, done;
  logic [DW-1:0] buf_wdata;
  logic [CW-1:0] w_idx, pix_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  conv_1x1_weight_scheduler #(
    .DATA_WIDTH(DW), .WEIGHT_NUM(WN), .PIXEL_NUM(PN), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .w_valid(w_valid),
    .w_data(w_data), .w_ready(w_ready), .pix_ready(pix_ready),
    .buf_rdata(buf_rdata), .buf_valid_in(buf_valid_in),
    .buf_wdata(buf_wdata), .buf_read(buf_read), .w_idx(w_idx),
    .pix_idx(pix_idx), .last_w(last_w), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight buffer model: write strobe -> DFF stage -> FIFO of depth WN.
  logic [DW-1:0] fifo_q[$];
  logic          dff_v = 1'b0;
  logic [DW-1:0] dff_d = '0;
  always @(posedge clk) begin
    if (buf_read) begin
      if (fifo_q.size() > 0) buf_rdata <= fifo_q.pop_front();
      else buf_rdata <= '0;
    end
    if (dff_v) begin
      if (fifo_q.size() == WN) void'(fifo_q.pop_front());
      fifo_q.push_back(dff_d);
    end
    dff_v <= buf_valid_in;
    dff_d <= buf_wdata;
  end

  // Observations of one kernel run.
  logic [DW-1:0] obs_data[$];
  int            obs_widx[$];
  int            obs_pix[$];
  bit            obs_last[$];
  int first_beat_edge, last_beat_edge, done_cyc, done_cnt, done_with_busy;
  int load_writes, run_writes, wready_low_load, wready_in_poke;
  int first_read_cyc, last_read_cyc, busy_after_done;
  bit timed_out;

  function automatic bit ready_at(input int k, input bit toggle);
    return toggle ? ((k % 2) == 1) : 1'b1;
  endfunction

  // Cycle (in posedge counts) at which done should first be seen: RUN starts
  // right after SETTLE, ends on the TOTAL-th pix_ready-high cycle, then DRAIN.
  function automatic int exp_done_cyc(input int last_edge, input bit toggle);
    int n = 0;
    for (int k = last_edge + 1; k < last_edge + 4 * TOTAL + 10; k++) begin
      if (ready_at(k, toggle)) begin
        n++;
        if (n == TOTAL) return k + DRAIN + 1;
      end
    end
    return -1;
  endfunction

  function automatic int data_errors(input logic [DW-1:0] wts [WN]);
    int e = 0;
    if (obs_data.size() != TOTAL) e++;
    for (int i = 0; i < obs_data.size(); i++)
      if (obs_data[i] !== wts[i % WN]) e++;
    return e;
  endfunction

  function automatic int idx_errors();
    int e = 0;
    if (obs_widx.size() != TOTAL) e++;
    for (int i = 0; i < obs_widx.size(); i++) begin
      if (obs_widx[i] != i % WN) e++;
      if (obs_pix[i] != i / WN) e++;
      if (obs_last[i] != (i % WN == WN - 1)) e++;
    end
    return e;
  endfunction

  // Runs one kernel from start to a couple of cycles past done, recording
  // what the DUT does. Inputs change on the falling edge; outputs are read 1ns
  // later.
  task automatic drive_kernel(input logic [DW-1:0] wts [WN], input bit gaps,
                              input bit toggle, input bit poke);
    int beat = 0, gap_wait = 0, t_last = -1, after_done = 0;
    bit prev_read = 1'b0;
    obs_data.delete(); obs_widx.delete(); obs_pix.delete(); obs_last.delete();
    first_beat_edge = -1; last_beat_edge = -1; done_cyc = -1;
    done_cnt = 0; done_with_busy = 0; load_writes = 0; run_writes = 0;
    wready_low_load = 0; wready_in_poke = 0; busy_after_done = 0;
    first_read_cyc = -1; last_read_cyc = -1; timed_out = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      start     = (t == 0);
      w_valid   = 1'b0;
      pix_ready = ready_at(cyc, toggle);
      if (t >= 1 && beat < WN) begin
        if (gap_wait > 0) gap_wait--;
        else begin
          w_valid = 1'b1;
          w_data  = wts[beat];
        end
      end
      if (poke && beat == WN && t > t_last && t <= t_last + 5) begin
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = $urandom;
      end
      #1;
      if (prev_read) obs_data.push_back(buf_rdata);
      prev_read = buf_read;
      if (buf_read) begin
        obs_widx.push_back(int'(w_idx));
        obs_pix.push_back(int'(pix_idx));
        obs_last.push_back(last_w);
        if (first_read_cyc < 0) first_read_cyc = cyc;
        last_read_cyc = cyc;
      end
      if (beat < WN) begin
        if (t >= 1 && !w_ready) wready_low_load++;
        if (buf_valid_in) load_writes++;
      end else begin
        if (buf_valid_in) run_writes++;
        if (poke && t > t_last && t <= t_last + 5 && w_ready) wready_in_poke++;
      end
      if (w_valid && w_ready && beat < WN) begin
        if (beat == 0) first_beat_edge = cyc + 1;
        last_beat_edge = cyc + 1;
        t_last = t;
        beat++;
        if (gaps && (beat == 1 || beat == 3)) gap_wait = 3;
      end
      if (done) begin
        done_cnt++;
        if (busy) done_with_busy++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (after_done > 0 && busy) busy_after_done++;
      if (done_cyc >= 0) after_done++;
      if (after_done >= 3) break;
    end
    start = 1'b0; w_valid = 1'b0; pix_ready = 1'b0;
    if (done_cyc < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, w_ready, buf_valid_in, buf_read, last_w} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, w_ready, buf_valid_in, buf_read, last_w});
    end
    checks++;
    if (w_idx !== '0) begin
      failures++; $display("FAIL reset_w_idx: got %0d want 0", w_idx);
    end
    checks++;
    if (pix_idx !== '0) begin
      failures++; $display("FAIL reset_pix_idx: got %0d want 0", pix_idx);
    end
    checks++;
    if (buf_wdata !== '0) begin
      failures++; $display("FAIL reset_wdata: got %h want 0", buf_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w [WN];
    int e;
    w = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive_kernel(w, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin
      failures++; $display("FAIL b2b_timeout: done never seen");
    end
    e = data_errors(w);
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL b2b_data: %0d bad of %0d reads, want 0", e, obs_data.size());
    end
    e = idx_errors();
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL b2b_idx: %0d index/last_w errors, want 0", e);
    end
    checks++;
    if (done_cyc - first_beat_edge !== WN + 1 + TOTAL + DRAIN - 1) begin
      failures++;
      $display("FAIL b2b_latency: got %0d want %0d", done_cyc - first_beat_edge,
               WN + 1 + TOTAL + DRAIN - 1);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt);
    end
    checks++;
    if (done_with_busy !== 0) begin
      failures++; $display("FAIL b2b_done_busy: got %0d want 0", done_with_busy);
    end
    checks++;
    if (load_writes !== WN) begin
      failures++; $display("FAIL b2b_load_writes: got %0d want %0d", load_writes, WN);
    end
    checks++;
    if (run_writes !== (PASSES > 1 ? TOTAL : 0)) begin
      failures++;
      $display("FAIL b2b_run_writes: got %0d want %0d", run_writes, PASSES > 1 ? TOTAL : 0);
    end
    checks++;
    if (busy_after_done !== 0) begin
      failures++; $display("FAIL b2b_busy_after_done: got %0d want 0", busy_after_done);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] w [WN];
    int e, want;
    for (int i = 0; i < WN; i++) w[i] = $urandom;
    drive_kernel(w, 1'b0, 1'b1, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin
      failures++; $display("FAIL stall_timeout: done never seen");
    end
    e = data_errors(w);
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL stall_data: %0d bad reads, want 0", e);
    end
    e = idx_errors();
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL stall_idx: %0d index/last_w errors, want 0", e);
    end
    want = exp_done_cyc(last_beat_edge, 1'b1);
    checks++;
    if (done_cyc !== want) begin
      failures++; $display("FAIL stall_done_cyc: got %0d want %0d", done_cyc, want);
    end
    checks++;
    if (last_read_cyc - first_read_cyc + 1 !== 2 * TOTAL - 1) begin
      failures++;
      $display("FAIL stall_run_span: got %0d want %0d",
               last_read_cyc - first_read_cyc + 1, 2 * TOTAL - 1);
    end
    checks++;
    if (run_writes !== (PASSES > 1 ? TOTAL : 0)) begin
      failures++;
      $display("FAIL stall_run_writes: got %0d want %0d", run_writes, PASSES > 1 ? TOTAL : 0);
    end
  endtask

  task automatic test_w_valid_gaps();
    logic [DW-1:0] w [WN];
    int e, want;
    for (int i = 0; i < WN; i++) w[i] = $urandom;
    drive_kernel(w, 1'b1, 1'b0, 1'b0);
    checks++;
    if (wready_low_load !== 0) begin
      failures++; $display("FAIL gaps_w_ready: low %0d cycles in LOAD, want 0", wready_low_load);
    end
    checks++;
    if (load_writes !== WN) begin
      failures++; $display("FAIL gaps_load_writes: got %0d want %0d", load_writes, WN);
    end
    checks++;
    if (last_beat_edge - first_beat_edge !== WN - 1 + 6) begin
      failures++;
      $display("FAIL gaps_load_span: got %0d want %0d", last_beat_edge - first_beat_edge, WN + 5);
    end
    e = data_errors(w);
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL gaps_data: %0d bad reads, want 0", e);
    end
    want = exp_done_cyc(last_beat_edge, 1'b0);
    checks++;
    if (done_cyc !== want) begin
      failures++; $display("FAIL gaps_done_cyc: got %0d want %0d", done_cyc, want);
    end
    checks++;
    if (run_writes !== (PASSES > 1 ? TOTAL : 0)) begin
      failures++;
      $display("FAIL gaps_run_writes: got %0d want %0d", run_writes, PASSES > 1 ? TOTAL : 0);
    end
  endtask

  task automatic test_ignore_inputs_during_run();
    logic [DW-1:0] w [WN];
    int e;
    for (int i = 0; i < WN; i++) w[i] = $urandom;
    drive_kernel(w, 1'b0, 1'b0, 1'b1);
    checks++;
    if (wready_in_poke !== 0) begin
      failures++; $display("FAIL poke_w_ready: high %0d cycles, want 0", wready_in_poke);
    end
    e = data_errors(w);
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL poke_data: %0d bad reads, want 0", e);
    end
    checks++;
    if (load_writes !== WN) begin
      failures++; $display("FAIL poke_load_writes: got %0d want %0d", load_writes, WN);
    end
    checks++;
    if (run_writes !== (PASSES > 1 ? TOTAL : 0)) begin
      failures++;
      $display("FAIL poke_run_writes: got %0d want %0d", run_writes, PASSES > 1 ? TOTAL : 0);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL poke_done_pulses: got %0d want 1", done_cnt);
    end
    checks++;
    if (busy_after_done !== 0) begin
      failures++; $display("FAIL poke_busy_after_done: got %0d want 0", busy_after_done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] w [WN];
    logic [DW-1:0] w2 [WN];
    int tgt_pix = (PASSES > 5) ? 5 : PASSES - 1;
    int beat = 0;
    int e;
    bit hit = 1'b0;
    for (int i = 0; i < WN; i++) w[i] = $urandom;
    for (int i = 0; i < WN; i++) w2[i] = $urandom;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(negedge clk);
      start     = (t == 0);
      pix_ready = 1'b1;
      w_valid   = 1'b0;
      if (t >= 1 && beat < WN) begin
        w_valid = 1'b1;
        w_data  = w[beat];
      end
      #1;
      if (w_valid && w_ready) beat++;
      if (buf_read && w_idx == CW'(2) && pix_idx == CW'(tgt_pix)) hit = 1'b1;
    end
    reset = 1'b1;
    start = 1'b0;
    w_valid = 1'b0;
    checks++;
    if (!hit) begin
      failures++; $display("FAIL midrun_reach: target read not seen, want w_idx=2 pix_idx=%0d", tgt_pix);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midrun_busy: got %b want 0", busy);
    end
    checks++;
    if ({done, w_ready, buf_valid_in, buf_read, last_w, w_idx, pix_idx} !== '0) begin
      failures++;
      $display("FAIL midrun_outputs: got %b want all zero",
               {done, w_ready, buf_valid_in, buf_read, last_w, w_idx, pix_idx});
    end
    reset = 1'b0;
    drive_kernel(w2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin
      failures++; $display("FAIL midrun_reload_timeout: done never seen");
    end
    e = data_errors(w2);
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL midrun_reload_data: %0d bad reads, want 0", e);
    end
    e = idx_errors();
    checks++;
    if (e !== 0) begin
      failures++; $display("FAIL midrun_reload_idx: %0d index/last_w errors, want 0", e);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_w_valid_gaps();
    test_ignore_inputs_during_run();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
